// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file: two read ports, byte-strobed write, debug read, clear sequencer
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [ADDR_W-1:0]     raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     which_reg,
  output logic [DATA_W-1:0]     reg_content,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int                NLANES = DATA_W / 8;
  localparam logic [ADDR_W:0]   NREGS  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic                wr_ok;

  // Entry 0 and anything beyond the implemented depth behave as absent.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS);
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ok = we && (state_q != CLEAR) && addr_ok(waddr);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wstrb[i]) mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    if (state_q == CLEAR) mem_d[ptr_q] = '0;
    mem_d[0] = '0;
  end

  always_comb begin
    rdata_a     = addr_ok(raddr_a)   ? mem_q[raddr_a]   : '0;
    rdata_b     = addr_ok(raddr_b)   ? mem_q[raddr_b]   : '0;
    reg_content = addr_ok(which_reg) ? mem_q[which_reg] : '0;
`ifdef REGFILE_BYPASS_EN
    // Forward strobed lanes of an accepted write; the debug port stays unforwarded.
    for (int i = 0; i < NLANES; i++) begin
      if (wr_ok && wstrb[i] && (raddr_a == waddr)) rdata_a[8*i +: 8] = wdata[8*i +: 8];
      if (wr_ok && wstrb[i] && (raddr_b == waddr)) rdata_b[8*i +: 8] = wdata[8*i +: 8];
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr_a = '0, raddr_b = '0, waddr = '0, which_reg = '0;
  logic [31:0] rdata_a, rdata_b, reg_content;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        we = 1'b0, clr_req = 1'b0;
  logic        clr_busy, clr_done;

  logic [4:0]  s_raddr_a = '0, s_raddr_b = '0, s_waddr = '0, s_which = '0;
  logic [31:0] s_rdata_a, s_rdata_b, s_content;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_we = 1'b0, s_clr_req = 1'b0;
  logic        s_busy, s_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .we(we),
    .which_reg(which_reg), .reg_content(reg_content),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(20)) dut20 (
    .clk(clk), .rst(rst),
    .raddr_a(s_raddr_a), .rdata_a(s_rdata_a), .raddr_b(s_raddr_b), .rdata_b(s_rdata_b),
    .waddr(s_waddr), .wdata(s_wdata), .wstrb(s_wstrb), .we(s_we),
    .which_reg(s_which), .reg_content(s_content),
    .clr_req(s_clr_req), .clr_busy(s_busy), .clr_done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr = a; wdata = d; wstrb = s; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_all(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr_a = a; raddr_b = a; which_reg = a;
    @(negedge clk);
    chk({tag, "_a"}, rdata_a, exp);
    chk({tag, "_b"}, rdata_b, exp);
    chk({tag, "_dbg"}, reg_content, exp);
  endtask

  initial begin
    int cnt;
    logic seen;

    // reset state
    tick(); tick();
    chk("rst_busy", {31'b0, clr_busy}, 32'd0);
    chk("rst_done", {31'b0, clr_done}, 32'd0);
    rst = 1'b1;
    tick();

    // random contents, then asynchronous reset clears everything
    for (int i = 1; i < 32; i++) wr(5'(i), $urandom | 32'h1, 4'hF);
    which_reg = 5'd9;
    #1;
    chk("pre_rst_nonzero", {31'b0, (reg_content != 0)}, 32'd1);
    rst = 1'b0;
    #2;
    for (int i = 0; i < 32; i++) rd_all("rst_clear", 5'(i), 32'h0);
    chk("rst_busy2", {31'b0, clr_busy}, 32'd0);
    chk("rst_done2", {31'b0, clr_done}, 32'd0);
    rst = 1'b1;
    tick();

    // byte strobes
    wr(5'd5, 32'h11223344, 4'hF);
    wr(5'd5, 32'hAABBCCDD, 4'b0101);
    rd_all("strb", 5'd5, 32'h11BB33DD);
    tick();
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    rd_all("addr0", 5'd0, 32'h0);
    tick();

    // same-cycle forwarding (or its absence)
    raddr_a = 5'd7; raddr_b = 5'd7; which_reg = 5'd7;
    waddr = 5'd7; wdata = 32'hDEADBEEF; wstrb = 4'hF; we = 1'b1;
    #1;
    chk("byp_a", rdata_a, BYP ? 32'hDEADBEEF : 32'h0);
    chk("byp_b", rdata_b, BYP ? 32'hDEADBEEF : 32'h0);
    chk("byp_dbg", reg_content, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("byp_next_a", rdata_a, 32'hDEADBEEF);
    chk("byp_next_b", rdata_b, 32'hDEADBEEF);
    waddr = 5'd7; wdata = 32'h00001111; wstrb = 4'b0011; we = 1'b1;
    #1;
    chk("byp_part_a", rdata_a, BYP ? 32'hDEAD1111 : 32'hDEADBEEF);
    chk("byp_part_dbg", reg_content, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #1;
    chk("part_store", reg_content, 32'hDEAD1111);

    // hardware clear
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFFFFFF, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      we = 1'b0; clr_req = 1'b0;
      if (cnt == 4) clr_req = 1'b1;
      if (cnt == 20) begin
        waddr = 5'd3; wdata = 32'h00000055; wstrb = 4'hF; we = 1'b1;
      end
      if (cnt == 16) begin
        which_reg = 5'd2;  raddr_a = 5'd30;
        #1;
        chk("mid_cleared", reg_content, 32'h0);
        chk("mid_uncleared", rdata_a, 32'hFFFFFFFF);
      end
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    chk("clr_busy_cycles", cnt, 32'd31);
    chk("clr_done_pulse", {31'b0, clr_done}, 32'd1);
    chk("clr_done_busy", {31'b0, clr_busy}, 32'd0);
    tick();
    chk("clr_done_one", {31'b0, clr_done}, 32'd0);
    chk("clr_no_restart", {31'b0, clr_busy}, 32'd0);
    for (int i = 0; i < 32; i++) rd_all("clr_zero", 5'(i), 32'h0);

    // reset in the middle of a clear
    wr(5'd10, 32'hCAFEF00D, 4'hF);
    wr(5'd31, 32'h0BADF00D, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("midrst_busy_before", {31'b0, clr_busy}, 32'd1);
    rst = 1'b0;
    #2;
    chk("midrst_busy", {31'b0, clr_busy}, 32'd0);
    chk("midrst_done", {31'b0, clr_done}, 32'd0);
    rd_all("midrst_e10", 5'd10, 32'h0);
    rd_all("midrst_e31", 5'd31, 32'h0);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clr_done === 1'b1 || clr_busy === 1'b1) seen = 1'b1;
    end
    chk("midrst_quiet", {31'b0, seen}, 32'd0);

    // out-of-range and boundary on a 20-entry instance
    s_waddr = 5'd25; s_wdata = 32'h12345678; s_wstrb = 4'hF; s_we = 1'b1;
    tick();
    s_waddr = 5'd19; s_wdata = 32'h19191919;
    tick();
    s_waddr = 5'd20; s_wdata = 32'h20202020;
    tick();
    s_we = 1'b0;
    s_raddr_a = 5'd25; s_raddr_b = 5'd25; s_which = 5'd25;
    #1;
    chk("oor25_a", s_rdata_a, 32'h0);
    chk("oor25_b", s_rdata_b, 32'h0);
    chk("oor25_dbg", s_content, 32'h0);
    s_raddr_a = 5'd19; s_raddr_b = 5'd20; s_which = 5'd19;
    #1;
    chk("last19_a", s_rdata_a, 32'h19191919);
    chk("last19_dbg", s_content, 32'h19191919);
    chk("oor20_b", s_rdata_b, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
